// File: rtl/sort_diverter_scheduler.sv
// Diverter gate scheduler: tracks classified packages in a slot table and
// pulses each bin's gate when its package has travelled that gate's distance.
module sort_diverter_scheduler #(
    parameter int SLOTS     = 8,
    parameter int TW        = 8,
    parameter int GATE_LEN  = 4,
    parameter int DIST_BASE = 10
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          ItemValid,
    input  logic [2:0]    ItemGrp,
    input  logic          Tick,
    input  logic          CfgWe,
    input  logic [2:0]    CfgAddr,
    input  logic [TW-1:0] CfgData,
    output logic [5:0]    Gate,
    output logic          ItemReady,
    output logic [4:0]    InFlight,
    output logic          Overflow,
    output logic [7:0]    DropCnt
);

    localparam int GW = $clog2(GATE_LEN + 1);
    localparam int SW = $clog2(SLOTS);

    logic [SLOTS-1:0] r_occ;
    logic [2:0]       r_grp [SLOTS];
    logic [TW-1:0]    r_cnt [SLOTS];
    logic [TW-1:0]    r_dist [6];
    logic [GW-1:0]    r_gtmr [6];
    logic             r_overflow;
    logic [7:0]       r_dropcnt;

    logic             w_grp_ok;
    logic             w_free_found;
    logic [SW-1:0]    w_free_idx;
    logic             w_accept;
    logic             w_drop;
    logic [SLOTS-1:0] w_fire;
    logic [5:0]       w_fire_grp;
    logic [TW-1:0]    w_dist_sel;
    logic [TW-1:0]    w_load_cnt;
    logic [4:0]       w_inflight;

    assign w_grp_ok = (ItemGrp != 3'd0) && (ItemGrp != 3'd7);

    // Lowest-index free slot; occupancy is sampled before this edge's frees.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!r_occ[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = SW'(i);
            end
        end
    end

    assign w_accept = ItemValid && w_grp_ok && w_free_found;
    assign w_drop   = ItemValid && w_grp_ok && !w_free_found;

    always_comb begin
        w_fire     = '0;
        w_fire_grp = '0;
        for (int i = 0; i < SLOTS; i++) begin
            w_fire[i] = Tick && r_occ[i] && (r_cnt[i] == TW'(1));
            for (int g = 0; g < 6; g++) begin
                if (w_fire[i] && (r_grp[i] == 3'(g + 1)))
                    w_fire_grp[g] = 1'b1;
            end
        end
    end

    always_comb begin
        w_dist_sel = '0;
        for (int g = 0; g < 6; g++) begin
            if (ItemGrp == 3'(g + 1))
                w_dist_sel = r_dist[g];
        end
        w_load_cnt = (w_dist_sel == '0) ? TW'(1) : w_dist_sel;
    end

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (r_occ[i])
                w_inflight = w_inflight + 5'd1;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_occ      <= '0;
            r_overflow <= 1'b0;
            r_dropcnt  <= '0;
            for (int g = 0; g < 6; g++) begin
                r_gtmr[g] <= '0;
                r_dist[g] <= TW'(DIST_BASE * (g + 1));
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (w_fire[i])
                    r_occ[i] <= 1'b0;
            end
            if (w_accept)
                r_occ[w_free_idx] <= 1'b1;

            // A fire on an already-open gate reloads its timer, stretching the pulse.
            for (int g = 0; g < 6; g++) begin
                if (w_fire_grp[g])
                    r_gtmr[g] <= GW'(GATE_LEN);
                else if (r_gtmr[g] != '0)
                    r_gtmr[g] <= r_gtmr[g] - GW'(1);
                if (CfgWe && (CfgAddr == 3'(g + 1)))
                    r_dist[g] <= CfgData;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropcnt != 8'hFF)
                    r_dropcnt <= r_dropcnt + 8'd1;
            end
        end
    end

    // Slot payload is only meaningful while the occupancy bit is set.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < SLOTS; i++) begin
            if (w_accept && (w_free_idx == SW'(i))) begin
                r_grp[i] <= ItemGrp;
                r_cnt[i] <= w_load_cnt;
            end else if (Tick && r_occ[i]) begin
                r_cnt[i] <= r_cnt[i] - TW'(1);
            end
        end
    end

    always_comb begin
        for (int g = 0; g < 6; g++)
            Gate[g] = (r_gtmr[g] != '0);
    end

    assign InFlight  = w_inflight;
    assign ItemReady = (w_inflight != 5'(SLOTS));
    assign Overflow  = r_overflow;
    assign DropCnt   = r_dropcnt;

endmodule

// File: tb/tb_sort_diverter_scheduler.sv
// Directed bench for sort_diverter_scheduler: linear steps with hand-computed expectations.
module tb_sort_diverter_scheduler;

    logic       CLK       = 1'b0;
    logic       Reset     = 1'b0;
    logic       ItemValid = 1'b0;
    logic [2:0] ItemGrp   = 3'd0;
    logic       Tick      = 1'b0;
    logic       CfgWe     = 1'b0;
    logic [2:0] CfgAddr   = 3'd0;
    logic [7:0] CfgData   = 8'd0;
    logic [5:0] Gate;
    logic       ItemReady;
    logic [4:0] InFlight;
    logic       Overflow;
    logic [7:0] DropCnt;

    int nvec = 0;
    int nerr = 0;
    int rises [6];
    int base  [6];
    logic [5:0] prev_gate = 6'd0;

    sort_diverter_scheduler #(
        .SLOTS(8), .TW(8), .GATE_LEN(4), .DIST_BASE(10)
    ) dut (
        .CLK(CLK), .Reset(Reset), .ItemValid(ItemValid), .ItemGrp(ItemGrp),
        .Tick(Tick), .CfgWe(CfgWe), .CfgAddr(CfgAddr), .CfgData(CfgData),
        .Gate(Gate), .ItemReady(ItemReady), .InFlight(InFlight),
        .Overflow(Overflow), .DropCnt(DropCnt)
    );

    always #5 CLK = ~CLK;

    initial for (int g = 0; g < 6; g++) rises[g] = 0;

    always @(negedge CLK) begin
        for (int g = 0; g < 6; g++)
            if (Gate[g] && !prev_gate[g]) rises[g] = rises[g] + 1;
        prev_gate = Gate;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic iv, input logic [2:0] g, input logic tk,
                        input logic we, input logic [2:0] a, input logic [7:0] d);
        @(negedge CLK);
        ItemValid = iv; ItemGrp = g; Tick = tk; CfgWe = we; CfgAddr = a; CfgData = d;
        @(posedge CLK);
        #1;
        ItemValid = 1'b0; ItemGrp = 3'd0; Tick = 1'b0; CfgWe = 1'b0; CfgAddr = 3'd0; CfgData = 8'd0;
    endtask

    task automatic idle();                     step(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 8'd0); endtask
    task automatic tick();                     step(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 8'd0); endtask
    task automatic accept(input logic [2:0] g); step(1'b1, g,    1'b0, 1'b0, 3'd0, 8'd0); endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset = 1'b0;
        repeat (2) @(negedge CLK);
        Reset = 1'b1;
    endtask

    task automatic snap();
        for (int g = 0; g < 6; g++) base[g] = rises[g];
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        Reset = 1'b1;
        #1;
        chk("rst_gate", Gate, 6'd0);
        chk("rst_inflight", InFlight, 5'd0);
        chk("rst_ready", ItemReady, 1'b1);
        chk("rst_ovf", Overflow, 1'b0);
        chk("rst_drop", DropCnt, 8'd0);

        // 1: single grp=2 package, dist 20
        snap();
        accept(3'd2);
        chk("t1_inflight1", InFlight, 5'd1);
        repeat (19) tick();
        chk("t1_gate_before", Gate, 6'd0);
        chk("t1_inflight_before", InFlight, 5'd1);
        tick();
        chk("t1_gate_rise", Gate, 6'b000010);
        chk("t1_inflight0", InFlight, 5'd0);
        repeat (3) idle();
        chk("t1_gate_held", Gate, 6'b000010);
        idle();
        chk("t1_gate_fall", Gate, 6'd0);
        chk("t1_rises", rises[1] - base[1], 1);

        // 2: out-of-order fire, grp6 (60) then grp1 (10) five ticks later
        snap();
        accept(3'd6);
        repeat (5) tick();
        accept(3'd1);
        chk("t2_inflight2", InFlight, 5'd2);
        repeat (9) tick();
        chk("t2_gate_pre1", Gate, 6'd0);
        tick();
        chk("t2_gate1", Gate, 6'b000001);
        chk("t2_inflight1", InFlight, 5'd1);
        repeat (44) tick();
        chk("t2_gate_pre6", Gate, 6'd0);
        tick();
        chk("t2_gate6", Gate, 6'b100000);
        chk("t2_inflight0", InFlight, 5'd0);
        repeat (4) idle();
        chk("t2_gate_off", Gate, 6'd0);
        chk("t2_rises0", rises[0] - base[0], 1);
        chk("t2_rises5", rises[5] - base[5], 1);

        // 3: fill table, drop, invalid groups, saturation
        for (int i = 0; i < 8; i++) accept(3'd1);
        chk("t3_full_inflight", InFlight, 5'd8);
        chk("t3_full_ready", ItemReady, 1'b0);
        chk("t3_full_ovf", Overflow, 1'b0);
        accept(3'd2);
        accept(3'd3);
        chk("t3_ovf", Overflow, 1'b1);
        chk("t3_drop2", DropCnt, 8'd2);
        chk("t3_inflight8", InFlight, 5'd8);
        accept(3'd0);
        accept(3'd7);
        chk("t3_invalid_nodrop", DropCnt, 8'd2);
        for (int i = 0; i < 260; i++) accept(3'd4);
        chk("t3_drop_sat", DropCnt, 8'd255);
        do_reset();
        #1;
        chk("t3_rst_ovf", Overflow, 1'b0);
        chk("t3_rst_drop", DropCnt, 8'd0);
        chk("t3_rst_inflight", InFlight, 5'd0);

        // Invalid group on an empty table allocates nothing
        accept(3'd0);
        chk("inv_noalloc", InFlight, 5'd0);

        // 4: dist 0 clamps to 1; accept+tick same cycle loads without decrement
        step(1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 8'd0);
        step(1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 8'd0);
        chk("t4_loaded", InFlight, 5'd1);
        chk("t4_nofire", Gate, 6'd0);
        tick();
        chk("t4_fire", Gate, 6'b000100);
        chk("t4_freed", InFlight, 5'd0);
        repeat (4) idle();
        chk("t4_off", Gate, 6'd0);
        // Accept in the same cycle as a Dist write sees the old value (0 -> cnt 1)
        step(1'b1, 3'd3, 1'b0, 1'b1, 3'd3, 8'd2);
        tick();
        chk("t4_olddist_fire", Gate, 6'b000100);
        repeat (4) idle();
        // New value (2) now in effect
        accept(3'd3);
        tick();
        chk("t4_newdist_wait", Gate, 6'd0);
        tick();
        chk("t4_newdist_fire", Gate, 6'b000100);
        repeat (4) idle();

        // 5: retrigger on grp4 with dist 5
        step(1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 8'd5);
        snap();
        accept(3'd4);
        tick();
        tick();
        step(1'b1, 3'd4, 1'b1, 1'b0, 3'd0, 8'd0);
        tick();
        chk("t5_pre", Gate, 6'd0);
        tick();
        chk("t5_a_fire", Gate, 6'b001000);
        chk("t5_inflight1", InFlight, 5'd1);
        tick();
        tick();
        chk("t5_hold", Gate, 6'b001000);
        tick();
        chk("t5_b_fire", Gate, 6'b001000);
        chk("t5_inflight0", InFlight, 5'd0);
        repeat (3) idle();
        chk("t5_ext", Gate, 6'b001000);
        idle();
        chk("t5_off", Gate, 6'd0);
        chk("t5_one_pulse", rises[3] - base[3], 1);

        // 6: asynchronous reset with slots occupied and Gate[0] high
        accept(3'd1);
        repeat (9) tick();
        accept(3'd1);
        accept(3'd1);
        accept(3'd1);
        tick();
        chk("t6_gate_up", Gate, 6'b000001);
        chk("t6_inflight3", InFlight, 5'd3);
        #2;
        Reset = 1'b0;
        #1;
        chk("t6_async_gate", Gate, 6'd0);
        chk("t6_async_inflight", InFlight, 5'd0);
        chk("t6_async_ready", ItemReady, 1'b1);
        @(negedge CLK);
        Reset = 1'b1;
        snap();
        repeat (15) tick();
        chk("t6_no_gate", Gate, 6'd0);
        chk("t6_no_rise", rises[0] - base[0], 0);
        chk("t6_empty", InFlight, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
